// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC interval sweep controller: FSM states,
// interval tables and the table lookup helper.
package tdc_pkg;

  localparam int VAL_W     = 28;
  localparam int GAP_W     = 27;
  localparam int N_ENTRIES = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FIRE = 3'd2,
    ST_ACK  = 3'd3,
    ST_WAIT = 3'd4,
    ST_GAP  = 3'd5,
    ST_NEXT = 3'd6
  } state_e;

  localparam logic [VAL_W-1:0] RANGE0_TABLE [N_ENTRIES] = '{
    28'd25, 28'd125, 28'd250, 28'd1250, 28'd2250
  };

  localparam logic [VAL_W-1:0] RANGE1_TABLE [N_ENTRIES] = '{
    28'd25000, 28'd125000, 28'd250000, 28'd1250000, 28'd2250000
  };

  // Out-of-table indices fall back to the shortest interval.
  function automatic logic [VAL_W-1:0] interval_lookup(input logic rng, input logic [2:0] idx);
    logic [VAL_W-1:0] val;
    case (idx)
      3'd0:    val = rng ? RANGE1_TABLE[0] : RANGE0_TABLE[0];
      3'd1:    val = rng ? RANGE1_TABLE[1] : RANGE0_TABLE[1];
      3'd2:    val = rng ? RANGE1_TABLE[2] : RANGE0_TABLE[2];
      3'd3:    val = rng ? RANGE1_TABLE[3] : RANGE0_TABLE[3];
      3'd4:    val = rng ? RANGE1_TABLE[4] : RANGE0_TABLE[4];
      default: val = RANGE0_TABLE[0];
    endcase
    return val;
  endfunction

endpackage

// File: rtl/tdc_gap_timer.sv
// Inter-pair gap timer: loadable 27-bit down-counter that flags the last
// counting cycle so the controller leaves GAP after exactly the loaded count.
module tdc_gap_timer
  import tdc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             cnt_en,
  input  logic [GAP_W-1:0] load_val,
  output logic             expire
);

  logic [GAP_W-1:0] count_q;
  logic [GAP_W-1:0] count_d;

  // next count: load wins, otherwise decrement while enabled and non-zero
  always_comb begin
    if (load) begin
      count_d = load_val;
    end else if (cnt_en && (count_q != {GAP_W{1'b0}})) begin
      count_d = count_q - GAP_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {GAP_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = cnt_en && (count_q == GAP_W'(1));

endmodule

// File: rtl/tdc_sweep_ctrl.sv
// TDC interval sweep controller: steps through an interval table, firing a
// burst of start/stop pairs per step with a fixed idle gap between pairs.
module tdc_sweep_ctrl
  import tdc_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int GAP_CYCLES = 100_663_296,
  parameter int NUM_STEPS  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              range_sel,
  input  logic              loop,
  input  logic              gen_ready,
  output logic              gen_fire,
  output logic [VAL_W-1:0]  interval,
  output logic [2:0]        step_idx,
  output logic [3:0]        burst_cnt,
  output logic              busy,
  output logic              done,
  output logic [4:0]        led
);

  localparam logic [3:0]       BURST_LAST = 4'(BURST_LEN);
  localparam logic [2:0]       STEP_LAST  = 3'(NUM_STEPS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES);

  state_e           state_q, state_d;
  logic             range_q, range_d;
  logic [VAL_W-1:0] interval_q, interval_d;
  logic [2:0]       step_q, step_d;
  logic [3:0]       burst_q, burst_d;
  logic             gen_fire_q, gen_fire_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [4:0]       led_q, led_d;

  logic timer_load_s;
  logic timer_en_s;
  logic timer_expire_s;
  logic abort_s;

  assign timer_en_s = (state_q == ST_GAP);
  assign abort_s    = abort && (state_q != ST_IDLE);

  tdc_gap_timer u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_s),
    .cnt_en   (timer_en_s),
    .load_val (GAP_LOAD),
    .expire   (timer_expire_s)
  );

  // next-state and next-output logic; abort overrides every transition
  always_comb begin
    state_d      = state_q;
    range_d      = range_q;
    interval_d   = interval_q;
    step_d       = step_q;
    burst_d      = burst_q;
    gen_fire_d   = 1'b0;
    done_d       = 1'b0;
    timer_load_s = 1'b0;

    if (abort_s) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            range_d = range_sel;
            step_d  = 3'd0;
            burst_d = 4'd0;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          interval_d = interval_lookup(range_q, step_q);
          state_d    = ST_FIRE;
        end
        ST_FIRE: begin
          if (gen_ready) begin
            gen_fire_d = 1'b1;
            state_d    = ST_ACK;
          end else begin
            state_d = ST_FIRE;
          end
        end
        // generator may still show the stale ready here, so skip one cycle
        ST_ACK: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (gen_ready) begin
            burst_d      = burst_q + 4'd1;
            timer_load_s = 1'b1;
            state_d      = ST_GAP;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_GAP: begin
          if (timer_expire_s) begin
            state_d = (burst_q < BURST_LAST) ? ST_FIRE : ST_NEXT;
          end else begin
            state_d = ST_GAP;
          end
        end
        ST_NEXT: begin
          burst_d = 4'd0;
          if (step_q < STEP_LAST) begin
            step_d  = step_q + 3'd1;
            state_d = ST_LOAD;
          end else if (loop) begin
            step_d  = 3'd0;
            state_d = ST_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    led_d  = 5'b00001 << step_d;
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      range_q    <= 1'b0;
      interval_q <= RANGE0_TABLE[0];
      step_q     <= 3'd0;
      burst_q    <= 4'd0;
      gen_fire_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      led_q      <= 5'b00001;
    end else begin
      state_q    <= state_d;
      range_q    <= range_d;
      interval_q <= interval_d;
      step_q     <= step_d;
      burst_q    <= burst_d;
      gen_fire_q <= gen_fire_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      led_q      <= led_d;
    end
  end

  assign gen_fire  = gen_fire_q;
  assign interval  = interval_q;
  assign step_idx  = step_q;
  assign burst_cnt = burst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign led       = led_q;

endmodule
